chunked_serial_adder: RTL

- Parametrised, multi-cycle successor to the 8-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock through one shared CHUNK-bit ripple slice, trading latency for area.
- Uses valid/ready handshakes on the input and output sides so it can sit between registered datapath stages.

---
 rtl/chunked_adder_pkg.sv | 19 +
 rtl/chunked_serial_adder_ripple_slice.sv | 26 ++
 rtl/chunked_serial_adder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared types and sizing helpers for the chunked serial adder.
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/chunked_serial_adder_ripple_slice.sv
// ripple_slice: CHUNK-bit combinational ripple-carry adder built from a
// chain of full adders.
module ripple_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands through one CHUNK-bit ripple
// slice, LSB chunk first. Define CHUNKED_ADDER_OVF_EN to add the ovf output.
module chunked_serial_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CHUNKED_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NCH = calc_nch(WIDTH, CHUNK);
  localparam int IW  = calc_idx_w(NCH);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             c_reg;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] s_sl;
  logic             c_sl;
  logic [WIDTH-1:0] acc_next;
  logic             last_chunk;

  assign a_sl       = a_reg[int'(idx)*CHUNK +: CHUNK];
  assign b_sl       = b_reg[int'(idx)*CHUNK +: CHUNK];
  assign last_chunk = (idx == IW'(NCH - 1));

  ripple_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (c_reg),
    .s    (s_sl),
    .cout (c_sl)
  );

  always_comb begin
    acc_next = acc_reg;
    acc_next[int'(idx)*CHUNK +: CHUNK] = s_sl;
  end

`ifdef CHUNKED_ADDER_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  logic ovf_next;
  assign ovf_next = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1] ^ c_sl;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      c_reg     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + ~cin, so invert b and the borrow-in once here.
            a_reg    <= a;
            b_reg    <= sub ? ~b : b;
            c_reg    <= cin ^ sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc_reg <= acc_next;
          c_reg   <= c_sl;
          if (last_chunk) begin
            sum       <= acc_next;
            cout      <= c_sl;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf       <= ovf_next;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
